// File: rtl/flag_generator.sv
// NZCV flag generation beside the ALU, plus the architectural flag register.
// Optional sticky overflow flag enabled by defining FLAG_GEN_STICKY_V_EN.
module flag_generator #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] result,
    input  logic [3:0]       ALUControl,
    input  logic             cout,
    input  logic             flag_we,
`ifdef FLAG_GEN_STICKY_V_EN
    input  logic             clr_sticky,
    output logic             sticky_v,
`endif
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             C,
    output logic [3:0]       flags_q
);

    localparam int unsigned MSB    = WIDTH - 1;
    localparam logic [3:0]  OP_ADD = 4'b0000;
    localparam logic [3:0]  OP_SUB = 4'b0001;

    logic [3:0] flags_d;
    logic       a_s;
    logic       b_s;
    logic       r_s;

    assign a_s = a[MSB];
    assign b_s = b[MSB];
    assign r_s = result[MSB];

    // Only the sign bits of the operands take part in flag generation.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{a[MSB-1:0], b[MSB-1:0]};

    // Combinational flags; logical and undefined codes force C and V low.
    always_comb begin
        Z = (result == '0);
        N = r_s;
        C = 1'b0;
        V = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                C = cout;
                V = (a_s == b_s) && (r_s != a_s);
            end
            OP_SUB: begin
                C = cout;
                V = (a_s != b_s) && (r_s != a_s);
            end
            default: begin
                C = 1'b0;
                V = 1'b0;
            end
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (flag_we) begin
            flags_d = {N, Z, C, V};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

`ifdef FLAG_GEN_STICKY_V_EN
    logic sticky_v_q;
    logic sticky_v_d;

    // Set wins over clear when both happen on the same edge.
    always_comb begin
        sticky_v_d = sticky_v_q;
        if (clr_sticky) begin
            sticky_v_d = 1'b0;
        end
        if (flag_we && V) begin
            sticky_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_v_q <= 1'b0;
        end else begin
            sticky_v_q <= sticky_v_d;
        end
    end

    assign sticky_v = sticky_v_q;
`endif

endmodule

// File: tb/tb_flag_generator.sv
// Directed and random checks of flag_generator using an expected-value queue.
module tb_flag_generator;

    localparam int unsigned WIDTH = 3;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_UND = 4'b0111;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic [3:0]       ALUControl;
    logic             cout;
    logic             flag_we;
    logic             Z;
    logic             N;
    logic             V;
    logic             C;
    logic [3:0]       flags_q;
`ifdef FLAG_GEN_STICKY_V_EN
    logic             clr_sticky;
    logic             sticky_v;
`endif

    int n_vec;
    int n_miss;
    logic [3:0] exp_q[$];

    flag_generator #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .result     (result),
        .ALUControl (ALUControl),
        .cout       (cout),
        .flag_we    (flag_we),
`ifdef FLAG_GEN_STICKY_V_EN
        .clr_sticky (clr_sticky),
        .sticky_v   (sticky_v),
`endif
        .Z          (Z),
        .N          (N),
        .V          (V),
        .C          (C),
        .flags_q    (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input logic [3:0] e);
        exp_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare it against the observed value.
    task automatic check(input string tag, input logic [3:0] obs);
        logic [3:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $error("FAIL %s observed=%b expected=<empty queue>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_miss++;
                $error("FAIL %s observed=%b expected=%b", tag, obs, e);
            end
        end
    endtask

    task automatic set_in(input logic [3:0] op, input logic [2:0] av, input logic [2:0] bv,
                          input logic [2:0] rv, input logic co);
        ALUControl = op;
        a          = av;
        b          = bv;
        result     = rv;
        cout       = co;
    endtask

    // Apply one combinational vector and check {N,Z,C,V}.
    task automatic comb(input string tag, input logic [3:0] op, input logic [2:0] av,
                        input logic [2:0] bv, input logic [2:0] rv, input logic co,
                        input logic [3:0] e_nzcv);
        set_in(op, av, bv, rv, co);
        push(e_nzcv);
        #1;
        check(tag, {N, Z, C, V});
    endtask

    function automatic int sval(input logic [2:0] x);
        return x[2] ? int'(x) - 8 : int'(x);
    endfunction

    initial begin
        logic [3:0] op;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [2:0] rr;
        logic [3:0] sum;
        logic       rc;
        logic       rv;
        int         s;

        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        flag_we = 1'b0;
        set_in(OP_ADD, 3'b000, 3'b000, 3'b000, 1'b0);
`ifdef FLAG_GEN_STICKY_V_EN
        clr_sticky = 1'b0;
`endif
        #2;
        push(4'b0000);
        check("reset_flags_q", flags_q);
`ifdef FLAG_GEN_STICKY_V_EN
        push(4'b0000);
        check("reset_sticky", {3'b000, sticky_v});
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Directed combinational vectors
        comb("add_zero",     OP_ADD, 3'b000, 3'b000, 3'b000, 1'b0, 4'b0100);
        comb("add_neg",      OP_ADD, 3'b000, 3'b111, 3'b111, 1'b0, 4'b1000);
        comb("add_carry",    OP_ADD, 3'b111, 3'b111, 3'b110, 1'b1, 4'b1010);
        comb("add_ovf",      OP_ADD, 3'b011, 3'b001, 3'b100, 1'b0, 4'b1001);
        comb("sub_zero",     OP_SUB, 3'b111, 3'b111, 3'b000, 1'b1, 4'b0110);
        comb("sub_ovf",      OP_SUB, 3'b011, 3'b100, 3'b111, 1'b0, 4'b1001);
        comb("sub_same_sgn", OP_SUB, 3'b011, 3'b011, 3'b100, 1'b1, 4'b1010);
        comb("and_cout",     OP_AND, 3'b111, 3'b111, 3'b111, 1'b1, 4'b1000);
        comb("or_neg",       OP_OR,  3'b100, 3'b010, 3'b110, 1'b1, 4'b1000);
        comb("xor_neg",      OP_XOR, 3'b010, 3'b000, 3'b101, 1'b1, 4'b1000);
        comb("undef_op",     OP_UND, 3'b011, 3'b001, 3'b000, 1'b1, 4'b0100);
        comb("undef_max",    4'b1111, 3'b011, 3'b001, 3'b100, 1'b1, 4'b1000);

        // Random vectors with expectations from a two's-complement model
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 5));
            ra = 3'($urandom);
            rb = 3'($urandom);
            rc = 1'b0;
            rv = 1'b0;
            case (op)
                OP_ADD: begin
                    sum = {1'b0, ra} + {1'b0, rb};
                    rr  = sum[2:0];
                    rc  = sum[3];
                    s   = sval(ra) + sval(rb);
                    rv  = (s > 3) || (s < -4);
                end
                OP_SUB: begin
                    sum = {1'b0, ra} + {1'b0, ~rb} + 4'd1;
                    rr  = sum[2:0];
                    rc  = sum[3];
                    s   = sval(ra) - sval(rb);
                    rv  = (s > 3) || (s < -4);
                end
                OP_AND:  rr = ra & rb;
                OP_OR:   rr = ra | rb;
                OP_XOR:  rr = ra ^ rb;
                default: rr = 3'($urandom);
            endcase
            set_in(op, ra, rb, rr,
                   ((op == OP_ADD) || (op == OP_SUB)) ? rc : 1'($urandom));
            push({rr[2], rr == 3'b000, rc, rv});
            #1;
            check($sformatf("rand%0d_op%0d", i, op), {N, Z, C, V});
        end

        // Register path
        @(negedge clk);
        flag_we = 1'b1;
        set_in(OP_ADD, 3'b111, 3'b111, 3'b110, 1'b1);
        @(posedge clk); #1;
        push(4'b1010);
        check("reg_write", flags_q);

        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        push(4'b0000);
        check("async_reset", flags_q);
        @(posedge clk); #1;
        push(4'b0000);
        check("reset_held", flags_q);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        push(4'b1010);
        check("reg_after_rel", flags_q);

        @(negedge clk);
        flag_we = 1'b0;
        set_in(OP_AND, 3'b000, 3'b000, 3'b000, 1'b0);
        @(posedge clk); #1;
        push(4'b1010);
        check("reg_hold", flags_q);

        @(negedge clk);
        flag_we = 1'b1;
        @(posedge clk); #1;
        push(4'b0100);
        check("reg_write2", flags_q);

`ifdef FLAG_GEN_STICKY_V_EN
        @(negedge clk);
        set_in(OP_ADD, 3'b011, 3'b001, 3'b100, 1'b0);
        @(posedge clk); #1;
        push(4'b0001);
        check("sticky_set", {3'b000, sticky_v});

        @(negedge clk);
        set_in(OP_ADD, 3'b001, 3'b001, 3'b010, 1'b0);
        @(posedge clk); #1;
        push(4'b0001);
        check("sticky_persist", {3'b000, sticky_v});

        @(negedge clk);
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        push(4'b0000);
        check("sticky_clear", {3'b000, sticky_v});

        @(negedge clk);
        set_in(OP_SUB, 3'b011, 3'b100, 3'b111, 1'b0);
        @(posedge clk); #1;
        push(4'b0001);
        check("sticky_set_wins", {3'b000, sticky_v});
        clr_sticky = 1'b0;
`endif

        @(negedge clk);
        flag_we = 1'b0;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL queue_drain observed=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
